// File: rtl/mole_scheduler.sv
// mole_scheduler: picks the lit hole, times the show and gap windows,
// resolves each appearance as hit or miss and tracks difficulty level.
module mole_scheduler #(
  parameter int          TICK_DIV     = 100_000,
  parameter int          SHOW_START   = 1000,
  parameter int          SHOW_MIN     = 300,
  parameter int          SHOW_STEP    = 50,
  parameter int          GAP_TICKS    = 400,
  parameter int          HITS_PER_LVL = 4,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] btn,
  output logic [3:0] mole_on,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic [3:0] level,
  output logic       busy
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
  localparam logic [15:0]   GAP_LAST = 16'(GAP_TICKS - 1);
  localparam logic [15:0]   START    = 16'(SHOW_START);
  localparam logic [15:0]   SMIN     = 16'(SHOW_MIN);
  localparam logic [15:0]   STEP     = 16'(SHOW_STEP);
  localparam logic [7:0]    HIT_LAST = 8'(HITS_PER_LVL - 1);

  typedef enum logic [1:0] {
    IDLE,
    GAP,
    SHOW
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [15:0]   tcnt, tcnt_n;
  logic [15:0]   lfsr;
  logic [1:0]    prev_hole, prev_n, pick;
  logic [3:0]    btn_s, btn_q, press;
  logic [7:0]    hit_cnt, hit_cnt_n;
  logic [3:0]    mole_n, level_n;
  logic          hit_n, miss_n, busy_n;
  logic          running, tick;
  logic [15:0]   dec, show_t;

  // prev_hole doubles as the lit hole while in SHOW
  assign running = (state == GAP) || (state == SHOW);
  assign tick    = running && (presc == PRE_MAX);
  assign pick    = (lfsr[1:0] == prev_hole) ? lfsr[1:0] + 2'd1
                                            : lfsr[1:0];
  assign dec     = STEP * {12'd0, level};
  assign show_t  = ((START > dec) && ((START - dec) > SMIN))
                   ? (START - dec) : SMIN;

  // input sampling, registered rising-edge detect and free-running LFSR
  always_ff @(posedge clk) begin
    if (!reset) begin
      btn_s <= '0;
      btn_q <= '0;
      press <= '0;
      lfsr  <= LFSR_SEED;
    end else begin
      btn_s <= btn;
      btn_q <= btn_s;
      press <= btn_s & ~btn_q;
      lfsr  <= {lfsr[14:0],
                lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  // state register and all registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      presc      <= '0;
      tcnt       <= '0;
      prev_hole  <= '0;
      hit_cnt    <= '0;
      mole_on    <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      level      <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      presc      <= presc_n;
      tcnt       <= tcnt_n;
      prev_hole  <= prev_n;
      hit_cnt    <= hit_cnt_n;
      mole_on    <= mole_n;
      hit_pulse  <= hit_n;
      miss_pulse <= miss_n;
      level      <= level_n;
      busy       <= busy_n;
    end
  end

  // next state, timers, scoring; correct press outranks wrong press/timeout
  always_comb begin
    state_n   = state;
    presc_n   = (!running || tick) ? '0 : presc + 1'b1;
    tcnt_n    = tick ? tcnt + 16'd1 : tcnt;
    prev_n    = prev_hole;
    hit_cnt_n = hit_cnt;
    mole_n    = mole_on;
    level_n   = level;
    hit_n     = 1'b0;
    miss_n    = 1'b0;
    if (!enable) begin
      state_n = IDLE;
      mole_n  = '0;
      presc_n = '0;
      tcnt_n  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_n = GAP;
          presc_n = '0;
          tcnt_n  = '0;
          mole_n  = '0;
        end
        GAP: begin
          if (tick && (tcnt == GAP_LAST)) begin
            state_n = SHOW;
            presc_n = '0;
            tcnt_n  = '0;
            prev_n  = pick;
            mole_n  = 4'b0001 << pick;
          end
        end
        SHOW: begin
          if (press[prev_hole]) begin
            hit_n = 1'b1;
            if (hit_cnt == HIT_LAST) begin
              hit_cnt_n = '0;
              if (level != 4'hF) level_n = level + 4'd1;
            end else begin
              hit_cnt_n = hit_cnt + 8'd1;
            end
          end else if (|press) begin
            miss_n = 1'b1;
          end else if (tick && (tcnt == show_t - 16'd1)) begin
            miss_n = 1'b1;
          end
          if (hit_n || miss_n) begin
            state_n = GAP;
            presc_n = '0;
            tcnt_n  = '0;
            mole_n  = '0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_mole_scheduler.sv
// tb_mole_scheduler: randomized rounds checked against an event-level
// model of hole choice, show/gap durations, scoring and level.
`timescale 1ns/1ps
module tb_mole_scheduler;

  localparam int TD = 10;
  localparam int SS = 20;
  localparam int SM = 8;
  localparam int ST = 4;
  localparam int GT = 5;
  localparam int HPL = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] btn = 4'd0;
  logic [3:0] mole_on, level;
  logic       hit_pulse, miss_pulse, busy;

  int n_cmp = 0;
  int n_fail = 0;

  logic [15:0] m_lfsr, m_pre;
  int m_prev, m_hits, m_level;

  int          r_gap, r_resp;
  logic [3:0]  r_mole, r_after, r_level;
  logic [15:0] r_pre;
  bit          r_stray, r_hit, r_miss, r_busy;

  mole_scheduler #(
    .TICK_DIV(TD), .SHOW_START(SS), .SHOW_MIN(SM),
    .SHOW_STEP(ST), .GAP_TICKS(GT), .HITS_PER_LVL(HPL),
    .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .btn(btn),
    .mole_on(mole_on), .hit_pulse(hit_pulse),
    .miss_pulse(miss_pulse), .level(level), .busy(busy)
  );

  always #5 clk = ~clk;

  // polynomial x^16 + x^14 + x^13 + x^11 + 1, shifting left
  function automatic logic [15:0] lfsr_next(logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  always @(posedge clk) begin
    m_pre  <= m_lfsr;
    m_lfsr <= reset ? lfsr_next(m_lfsr) : SEED;
  end

  function automatic int show_cycles(int lvl);
    int t;
    t = SS - lvl * ST;
    if (t < SM) t = SM;
    return t * TD;
  endfunction

  function automatic int pick_hole(logic [15:0] pre, int prev);
    int h;
    h = int'(pre[1:0]);
    if (h == prev) h = (h + 1) % 4;
    return h;
  endfunction

  task automatic model_reset();
    m_prev = 0;
    m_hits = 0;
    m_level = 0;
  endtask

  task automatic model_hit();
    m_hits++;
    if (m_hits == HPL) begin
      m_hits = 0;
      if (m_level < 15) m_level++;
    end
  endtask

  task automatic wait_mole();
    r_gap = 0;
    r_stray = 0;
    do begin
      @(negedge clk);
      r_gap++;
      if (hit_pulse || miss_pulse) r_stray = 1;
    end while (mole_on == 4'd0 && r_gap < 2000);
    r_mole = mole_on;
    r_pre = m_pre;
    r_busy = busy;
    r_level = level;
  endtask

  task automatic respond(input int d, input int mode);
    logic [3:0] wrong;
    int rot;
    for (int i = 0; i < d; i++) begin
      @(negedge clk);
      if (hit_pulse || miss_pulse) r_stray = 1;
    end
    rot = $urandom_range(3, 1);
    wrong = 4'((r_mole << rot) | (r_mole >> (4 - rot)));
    case (mode)
      1: btn = r_mole;
      2: btn = wrong;
      3: btn = r_mole | wrong;
      default: btn = 4'd0;
    endcase
    r_resp = 0;
    do begin
      @(negedge clk);
      r_resp++;
    end while (!hit_pulse && !miss_pulse && r_resp < 2000);
    r_hit = hit_pulse;
    r_miss = miss_pulse;
    r_after = mole_on;
    btn = 4'd0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    enable = 1'b0;
    btn = 4'd0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({mole_on, hit_pulse, miss_pulse, level, busy} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_outs: got mole=%b hit=%b miss=%b lvl=%0d busy=%b want all 0",
               mole_on, hit_pulse, miss_pulse, level, busy);
    end
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_first_mole();
    int h;
    logic [3:0] em;
    enable = 1'b1;
    wait_mole();
    h = pick_hole(r_pre, m_prev);
    em = 4'b0001 << h;
    n_cmp++;
    if (r_gap !== GT * TD + 1) begin
      n_fail++;
      $display("FAIL first_gap: got %0d want %0d", r_gap, GT * TD + 1);
    end
    n_cmp++;
    if (r_mole !== em) begin
      n_fail++;
      $display("FAIL first_hole: got %b want %b", r_mole, em);
    end
    n_cmp++;
    if ({r_busy, r_stray} !== 2'b10) begin
      n_fail++;
      $display("FAIL first_busy: got busy=%b stray=%b want 1 0", r_busy, r_stray);
    end
    m_prev = h;
    respond(0, 0);
    n_cmp++;
    if (r_resp !== show_cycles(m_level)) begin
      n_fail++;
      $display("FAIL first_show: got %0d want %0d", r_resp, show_cycles(m_level));
    end
    n_cmp++;
    if ({r_hit, r_miss, r_after} !== 6'b010000) begin
      n_fail++;
      $display("FAIL first_miss: got hit=%b miss=%b mole=%b want 0 1 0000",
               r_hit, r_miss, r_after);
    end
  endtask

  task automatic test_timeouts();
    int h, old;
    logic [3:0] em;
    repeat (3) begin
      old = m_prev;
      wait_mole();
      h = pick_hole(r_pre, m_prev);
      em = 4'b0001 << h;
      m_prev = h;
      n_cmp++;
      if (r_gap !== GT * TD || r_mole !== em || r_stray) begin
        n_fail++;
        $display("FAIL to_mole: got gap=%0d mole=%b stray=%b want %0d %b 0",
                 r_gap, r_mole, r_stray, GT * TD, em);
      end
      n_cmp++;
      if (r_mole[old[1:0]] !== 1'b0) begin
        n_fail++;
        $display("FAIL to_repeat: got mole=%b want hole %0d dark", r_mole, old);
      end
      respond(0, 0);
      n_cmp++;
      if (r_resp !== show_cycles(m_level) || {r_hit, r_miss} !== 2'b01) begin
        n_fail++;
        $display("FAIL to_show: got %0d hit=%b miss=%b want %0d 0 1",
                 r_resp, r_hit, r_miss, show_cycles(m_level));
      end
    end
  endtask

  task automatic test_random_rounds();
    int h, sc, d, mode, er;
    bit eh;
    logic [3:0] em;
    repeat (24) begin
      wait_mole();
      h = pick_hole(r_pre, m_prev);
      em = 4'b0001 << h;
      m_prev = h;
      n_cmp++;
      if (r_gap !== GT * TD || r_mole !== em || r_level !== 4'(m_level)) begin
        n_fail++;
        $display("FAIL rnd_mole: got gap=%0d mole=%b lvl=%0d want %0d %b %0d",
                 r_gap, r_mole, r_level, GT * TD, em, m_level);
      end
      sc = show_cycles(m_level);
      d = $urandom_range(sc - 1, 0);
      mode = $urandom_range(3, 1);
      respond(d, mode);
      if (d + 3 <= sc) begin
        er = 3;
        eh = (mode != 2);
      end else begin
        er = sc - d;
        eh = 1'b0;
      end
      n_cmp++;
      if (r_resp !== er || r_hit !== eh || r_miss !== !eh ||
          r_after !== 4'd0 || r_stray) begin
        n_fail++;
        $display("FAIL rnd_resp: mode=%0d d=%0d got t=%0d hit=%b miss=%b mole=%b want t=%0d hit=%b",
                 mode, d, r_resp, r_hit, r_miss, r_after, er, eh);
      end
      if (eh) model_hit();
    end
  endtask

  task automatic test_boundary();
    int h, sc;
    for (int k = 0; k < 2; k++) begin
      wait_mole();
      h = pick_hole(r_pre, m_prev);
      m_prev = h;
      sc = show_cycles(m_level);
      respond(sc - 3 + k, 1);
      n_cmp++;
      if (r_resp !== 3 - k || r_hit !== (k == 0) || r_miss !== (k == 1)) begin
        n_fail++;
        $display("FAIL edge_press%0d: got t=%0d hit=%b miss=%b want t=%0d hit=%b",
                 k, r_resp, r_hit, r_miss, 3 - k, k == 0);
      end
      if (k == 0) model_hit();
    end
  endtask

  task automatic test_simultaneous();
    int h;
    for (int mode = 3; mode >= 2; mode--) begin
      wait_mole();
      h = pick_hole(r_pre, m_prev);
      m_prev = h;
      respond($urandom_range(60, 0), mode);
      n_cmp++;
      if (r_resp !== 3 || r_hit !== (mode == 3) || r_miss !== (mode == 2) ||
          r_after !== 4'd0) begin
        n_fail++;
        $display("FAIL simul_m%0d: got t=%0d hit=%b miss=%b mole=%b want 3 %b %b",
                 mode, r_resp, r_hit, r_miss, r_after, mode == 3, mode == 2);
      end
      if (mode == 3) model_hit();
    end
  endtask

  task automatic test_gap_press();
    int h;
    logic [3:0] em;
    repeat (5) @(negedge clk);
    btn = 4'hF;
    repeat (2) @(negedge clk);
    btn = 4'd0;
    wait_mole();
    h = pick_hole(r_pre, m_prev);
    em = 4'b0001 << h;
    m_prev = h;
    n_cmp++;
    if (r_gap !== GT * TD - 7 || r_stray || r_mole !== em) begin
      n_fail++;
      $display("FAIL gap_press: got gap=%0d stray=%b mole=%b want %0d 0 %b",
               r_gap, r_stray, r_mole, GT * TD - 7, em);
    end
    respond(10, 1);
    n_cmp++;
    if (r_hit !== 1'b1) begin
      n_fail++;
      $display("FAIL gap_hit: got hit=%b want 1", r_hit);
    end
    model_hit();
  endtask

  task automatic test_disable();
    int h;
    bit stray;
    logic [3:0] em;
    wait_mole();
    m_prev = pick_hole(r_pre, m_prev);
    repeat ($urandom_range(100, 1)) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({mole_on, hit_pulse, miss_pulse, busy} !== 7'd0 ||
        level !== 4'(m_level)) begin
      n_fail++;
      $display("FAIL disable: got mole=%b hit=%b miss=%b busy=%b lvl=%0d want 0 0 0 0 %0d",
               mole_on, hit_pulse, miss_pulse, busy, level, m_level);
    end
    stray = 0;
    repeat (20) begin
      @(negedge clk);
      if (hit_pulse || miss_pulse || mole_on != 4'd0) stray = 1;
    end
    n_cmp++;
    if (stray !== 1'b0) begin
      n_fail++;
      $display("FAIL disable_quiet: got activity=%b want 0", stray);
    end
    enable = 1'b1;
    wait_mole();
    h = pick_hole(r_pre, m_prev);
    em = 4'b0001 << h;
    m_prev = h;
    n_cmp++;
    if (r_gap !== GT * TD + 1 || r_mole !== em || r_level !== 4'(m_level)) begin
      n_fail++;
      $display("FAIL reenable: got gap=%0d mole=%b lvl=%0d want %0d %b %0d",
               r_gap, r_mole, r_level, GT * TD + 1, em, m_level);
    end
    respond(0, 0);
  endtask

  task automatic test_reset_mid();
    int h;
    logic [3:0] em;
    wait_mole();
    m_prev = pick_hole(r_pre, m_prev);
    repeat ($urandom_range(100, 1)) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({mole_on, hit_pulse, miss_pulse, level, busy} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got mole=%b hit=%b miss=%b lvl=%0d busy=%b want all 0",
               mole_on, hit_pulse, miss_pulse, level, busy);
    end
    reset = 1'b1;
    model_reset();
    wait_mole();
    h = pick_hole(r_pre, m_prev);
    em = 4'b0001 << h;
    m_prev = h;
    n_cmp++;
    if (r_gap !== GT * TD + 1 || r_mole !== em || r_stray) begin
      n_fail++;
      $display("FAIL post_reset: got gap=%0d mole=%b stray=%b want %0d %b 0",
               r_gap, r_mole, r_stray, GT * TD + 1, em);
    end
    respond(0, 0);
  endtask

  task automatic test_levels();
    int n;
    for (int phase = 0; phase < 2; phase++) begin
      n = (phase == 0) ? 12 : 4;
      repeat (n) begin
        wait_mole();
        m_prev = pick_hole(r_pre, m_prev);
        respond($urandom_range(show_cycles(m_level) - 4, 0),
                ($urandom_range(1, 0) == 0) ? 1 : 3);
        n_cmp++;
        if (r_hit !== 1'b1) begin
          n_fail++;
          $display("FAIL lvl_hit: got hit=%b want 1", r_hit);
        end
        model_hit();
      end
      wait_mole();
      m_prev = pick_hole(r_pre, m_prev);
      n_cmp++;
      if (level !== 4'(m_level)) begin
        n_fail++;
        $display("FAIL lvl_val%0d: got %0d want %0d", phase, level, m_level);
      end
      respond(0, 0);
      n_cmp++;
      if (r_resp !== show_cycles(m_level) || r_miss !== 1'b1) begin
        n_fail++;
        $display("FAIL lvl_show%0d: got %0d miss=%b want %0d 1",
                 phase, r_resp, r_miss, show_cycles(m_level));
      end
    end
  endtask

  task automatic test_saturate();
    int n;
    n = 0;
    while (m_level < 15 || n < 4) begin
      if (m_level == 15) n++;
      wait_mole();
      m_prev = pick_hole(r_pre, m_prev);
      respond($urandom_range(40, 0), 1);
      n_cmp++;
      if (r_hit !== 1'b1) begin
        n_fail++;
        $display("FAIL sat_hit: got hit=%b want 1", r_hit);
      end
      model_hit();
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (level !== 4'(m_level)) begin
      n_fail++;
      $display("FAIL sat_level: got %0d want %0d", level, m_level);
    end
  endtask

  initial begin
    test_reset();
    test_first_mole();
    test_timeouts();
    test_random_rounds();
    test_boundary();
    test_simultaneous();
    test_gap_press();
    test_disable();
    test_reset_mid();
    test_levels();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
